// File: rtl/buffer_uart_tx.sv
// buffer_uart_tx: drains an 8x8 LIFO/FIFO buffer through an 8N1 UART transmitter.
// Ports: CLK, RST (async high), EN, EMPTY, RD_DATA[7:0] in; REN, TXD, BUSY, TX_DONE, BYTE_CNT[7:0] out.
module buffer_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       EMPTY,
  input  logic [7:0] RD_DATA,
  output logic       REN,
  output logic       TXD,
  output logic       BUSY,
  output logic       TX_DONE,
  output logic [7:0] BYTE_CNT
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic        ren_q, ren_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        baud_end;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ren_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ren_d    = 1'b0;
    txd_d    = txd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    baud_end = (baud_q == BAUD_LAST);
    unique case (state_q)
      S_IDLE: begin
        if (EN && !EMPTY) begin
          state_d = S_POP;
          ren_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_POP: begin
        state_d = S_LOAD;
      end
      // Buffer OUT has settled one edge after REN was sampled.
      S_LOAD: begin
        shift_d = RD_DATA;
        txd_d   = 1'b0;
        baud_d  = 16'd0;
        bit_d   = 3'd0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          txd_d   = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            // Next bit is shift_q[1], which becomes shift[0] after this shift.
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign REN      = ren_q;
  assign TXD      = txd_q;
  assign BUSY     = busy_q;
  assign TX_DONE  = done_q;
  assign BYTE_CNT = cnt_q;

endmodule
